// File: rtl/cs_result_drain.sv
// cs_result_drain: column drain below the systolic PE array.
// Resolves the bottom PE's carry-save {sum, carry} pair, accumulates the
// resolved value across K-tiles with signed saturation, and queues each
// finished result in a small show-ahead FIFO for the writeback stage.
// The input is throttled so that a result leaving the accumulator can never
// meet a full FIFO.
module cs_result_drain #(
  parameter int ACC_WIDTH  = 24,
  parameter int OUT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [2*ACC_WIDTH-1:0]        i_y_p,
  input  logic                          i_valid,
  input  logic                          i_first,
  input  logic                          i_last,
  output logic                          o_ready,
  output logic [OUT_WIDTH-1:0]          o_data,
  output logic                          o_sat,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [OUT_WIDTH-1:0] MAX_V = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MIN_V = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic                 accept;
  logic [ACC_WIDTH-1:0] r_raw;
  logic [OUT_WIDTH-1:0] r_ext;

  logic                 s1_valid_q, s1_first_q, s1_last_q;
  logic [OUT_WIDTH-1:0] s1_r_q;

  logic [OUT_WIDTH-1:0] acc_q;
  logic                 sat_q;
  logic                 grp_done_q;

  logic                 grp_start;
  logic [OUT_WIDTH-1:0] base;
  logic [OUT_WIDTH:0]   sum_wide;
  logic                 ovf;
  logic [OUT_WIDTH-1:0] acc_d;
  logic                 sat_d;

  logic [OUT_WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 push, pop;

  // Carry-save resolve is modular: wrap to ACC_WIDTH, then sign-extend.
  assign r_raw  = i_y_p[2*ACC_WIDTH-1:ACC_WIDTH] + i_y_p[ACC_WIDTH-1:0];
  assign r_ext  = OUT_WIDTH'($signed(r_raw));
  assign accept = i_valid & o_ready;

  // A last beat sitting in S1 is counted as already occupying a FIFO slot,
  // so a push can never land on a full FIFO; a same-cycle pop is not credited.
  assign o_ready = rst_n &
                   (({1'b0, count_q} + {{CW{1'b0}}, s1_valid_q & s1_last_q})
                    < (CW+1)'(FIFO_DEPTH));

  // S1: capture the resolved beat and its group markers on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_r_q     <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_first_q <= i_first;
        s1_last_q  <= i_last;
        s1_r_q     <= r_ext;
      end
    end
  end

  // S2 datapath: pick the base, add one bit wider, clamp on signed overflow.
  // A group also starts after a completed result, even without i_first.
  always_comb begin
    grp_start = s1_first_q | grp_done_q;
    base      = grp_start ? '0 : acc_q;
    sum_wide  = {base[OUT_WIDTH-1], base} + {s1_r_q[OUT_WIDTH-1], s1_r_q};
    ovf       = sum_wide[OUT_WIDTH] ^ sum_wide[OUT_WIDTH-1];
    acc_d     = sum_wide[OUT_WIDTH-1:0];
    if (ovf) begin
      acc_d = sum_wide[OUT_WIDTH] ? MIN_V : MAX_V;
    end
    sat_d     = (sat_q & ~grp_start) | ovf;
  end

  // S2 state: accumulator, sticky saturation flag and group-complete marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      sat_q      <= 1'b0;
      grp_done_q <= 1'b1;
    end else if (s1_valid_q) begin
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      grp_done_q <= s1_last_q;
    end
  end

  assign push    = s1_valid_q & s1_last_q;
  assign pop     = o_valid & i_ready;
  assign o_valid = (count_q != '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q][OUT_WIDTH-1:0];
  assign o_sat   = mem_q[rd_ptr_q][OUT_WIDTH];

  // FIFO storage; cleared on reset so the head reads zero with nothing stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= {sat_d, acc_d};
    end
  end

  // FIFO pointers wrap naturally at the power-of-two depth; occupancy tracks push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_cs_result_drain.sv
// Bench for cs_result_drain: a default (32-bit) instance and a 25-bit
// instance share the same stimulus; a queue-based model predicts results.
module tb_cs_result_drain;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] i_y_p;
  logic        i_valid, i_first, i_last, i_ready;

  logic        o_ready, o_sat, o_valid;
  logic [31:0] o_data;
  logic [2:0]  o_count;
  logic        o_ready25, o_sat25, o_valid25;
  logic [24:0] o_data25;
  logic [2:0]  o_count25;

  always #5 clk = ~clk;

  cs_result_drain dut (
    .clk(clk), .rst_n(rst_n), .i_y_p(i_y_p), .i_valid(i_valid),
    .i_first(i_first), .i_last(i_last), .o_ready(o_ready), .o_data(o_data),
    .o_sat(o_sat), .o_valid(o_valid), .i_ready(i_ready), .o_count(o_count)
  );

  cs_result_drain #(.ACC_WIDTH(24), .OUT_WIDTH(25), .FIFO_DEPTH(4)) dut25 (
    .clk(clk), .rst_n(rst_n), .i_y_p(i_y_p), .i_valid(i_valid),
    .i_first(i_first), .i_last(i_last), .o_ready(o_ready25), .o_data(o_data25),
    .o_sat(o_sat25), .o_valid(o_valid25), .i_ready(i_ready), .o_count(o_count25)
  );

  typedef struct { logic [23:0] s; logic [23:0] c; bit f; bit l; } beat_t;
  typedef struct { longint d32; bit s32; longint d25; bit s25; } res_t;

  beat_t       beat_q[$];
  res_t        exp_q[$];
  res_t        pend;
  bit          pend_v, pend_last;
  longint      acc32, acc25;
  bit          sat32, sat25, grp_done;
  logic [32:0] got32[$];
  logic [25:0] got25[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint resolve(logic [23:0] s, logic [23:0] c);
    logic signed [23:0] t;
    longint v;
    t = s + c;
    v = t;
    return v;
  endfunction

  function automatic longint clampw(longint v, int w, output bit c);
    longint mx, mn;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    c = 1'b0;
    if (v > mx) begin c = 1'b1; return mx; end
    if (v < mn) begin c = 1'b1; return mn; end
    return v;
  endfunction

  function automatic bit model_ready();
    return rst_n && ((exp_q.size() + ((pend_v && pend_last) ? 1 : 0)) < D);
  endfunction

  task automatic model_clear();
    beat_q.delete();
    exp_q.delete();
    pend_v = 0; pend_last = 0;
    acc32 = 0; acc25 = 0; sat32 = 0; sat25 = 0; grp_done = 1;
  endtask

  task automatic model_accept(input beat_t b);
    longint r, v;
    bit start, c;
    r = resolve(b.s, b.c);
    start = b.f || grp_done;
    v = clampw((start ? 0 : acc32) + r, 32, c);
    sat32 = (start ? 1'b0 : sat32) | c;
    acc32 = v;
    v = clampw((start ? 0 : acc25) + r, 25, c);
    sat25 = (start ? 1'b0 : sat25) | c;
    acc25 = v;
    grp_done = b.l;
    pend.d32 = acc32; pend.s32 = sat32; pend.d25 = acc25; pend.s25 = sat25;
    pend_last = b.l;
  endtask

  task automatic compare();
    if (!rst_n) begin
      chk("rst_o_ready", {63'd0, o_ready}, 64'd0);
      chk("rst_o_valid", {63'd0, o_valid}, 64'd0);
      chk("rst_o_count", {61'd0, o_count}, 64'd0);
      chk("rst_o_data", {32'd0, o_data}, 64'd0);
      chk("rst_o_valid25", {63'd0, o_valid25}, 64'd0);
    end else begin
      chk("o_ready", {63'd0, o_ready}, {63'd0, model_ready()});
      chk("o_ready25", {63'd0, o_ready25}, {63'd0, model_ready()});
      chk("o_count", {61'd0, o_count}, 64'(exp_q.size()));
      chk("o_count25", {61'd0, o_count25}, 64'(exp_q.size()));
      chk("o_valid", {63'd0, o_valid}, {63'd0, exp_q.size() > 0});
      chk("o_valid25", {63'd0, o_valid25}, {63'd0, exp_q.size() > 0});
      if (exp_q.size() > 0) begin
        chk("o_data", {32'd0, o_data}, {32'd0, 32'(exp_q[0].d32)});
        chk("o_sat", {63'd0, o_sat}, {63'd0, exp_q[0].s32});
        chk("o_data25", {39'd0, o_data25}, {39'd0, 25'(exp_q[0].d25)});
        chk("o_sat25", {63'd0, o_sat25}, {63'd0, exp_q[0].s25});
      end
    end
  endtask

  // One clock: check and drive on the falling edge, advance the model after the rising edge.
  task automatic tick();
    bit acc, pop;
    beat_t b;
    @(negedge clk);
    compare();
    pop = rst_n && (exp_q.size() > 0) && i_ready;
    if (rst_n && o_valid && i_ready) got32.push_back({o_sat, o_data});
    if (rst_n && o_valid25 && i_ready) got25.push_back({o_sat25, o_data25});
    acc = 0;
    if (rst_n && beat_q.size() > 0) begin
      b = beat_q[0];
      i_valid = 1'b1; i_y_p = {b.s, b.c}; i_first = b.f; i_last = b.l;
      acc = model_ready();
    end else begin
      i_valid = 1'b0;
      i_y_p   = 48'({$urandom(), $urandom()});
      i_first = 1'($urandom_range(0, 1));
      i_last  = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (pop) void'(exp_q.pop_front());
      if (pend_v && pend_last) exp_q.push_back(pend);
      pend_v = acc;
      if (acc) begin
        void'(beat_q.pop_front());
        model_accept(b);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [23:0] s, input logic [23:0] c, input bit f, input bit l);
    beat_t b;
    b.s = s; b.c = c; b.f = f; b.l = l;
    beat_q.push_back(b);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((beat_q.size() > 0 || pend_v || exp_q.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (beat_q.size() > 0 || pend_v || exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats/%0d results still pending after %0d cycles",
               beat_q.size(), exp_q.size(), budget);
    end
  endtask

  function automatic logic [63:0] at32(int i);
    return (i < got32.size()) ? {31'd0, got32[i]} : '1;
  endfunction

  function automatic logic [63:0] at25(int i);
    return (i < got25.size()) ? {38'd0, got25[i]} : '1;
  endfunction

  initial begin
    int n0, m0;
    i_valid = 0; i_first = 0; i_last = 0; i_y_p = '0; i_ready = 0;
    model_clear();
    run(3);
    rst_n = 1'b1;
    #1;
    chk("ready_after_release", {63'd0, o_ready}, 64'd1);

    // T1 single tile and two-edge latency
    send(24'h000010, 24'h000005, 1, 1);
    tick();
    chk("t1_valid_edge1", {63'd0, o_valid}, 64'd0);
    tick();
    chk("t1_valid_edge2", {63'd0, o_valid}, 64'd1);
    chk("t1_data", {32'd0, o_data}, 64'd21);
    chk("t1_sat", {63'd0, o_sat}, 64'd0);
    i_ready = 1;
    n0 = got32.size();
    drain(50);
    chk("t1_out", at32(n0), 64'd21);

    // T2 modular resolve
    n0 = got32.size();
    send(24'hFFFFFF, 24'h000003, 1, 1);
    send(24'h800000, 24'h000000, 1, 1);
    drain(50);
    chk("t2_wrap", at32(n0), 64'd2);
    chk("t2_neg", at32(n0 + 1), 64'h0FF800000);

    // T3 three-tile group: 100, -30, 7
    n0 = got32.size();
    send(24'd100, 24'd0, 1, 0);
    send(24'hFFFFD8, 24'd10, 0, 0);
    send(24'd3, 24'd4, 0, 1);
    drain(50);
    chk("t3_count", 64'(got32.size() - n0), 64'd1);
    chk("t3_sum", at32(n0), 64'd77);

    // T4 saturation at 25 bits, clean next group, group without i_first
    n0 = got32.size();
    m0 = got25.size();
    send(24'h7FFFFF, 24'd0, 1, 0);
    send(24'h7FFFFF, 24'd0, 0, 0);
    send(24'h7FFFFF, 24'd0, 0, 1);
    send(24'd5, 24'd0, 1, 1);
    send(24'd4, 24'd0, 0, 0);
    send(24'hFFFFFF, 24'd7, 0, 1);
    drain(80);
    chk("t4_sat25", at25(m0), {38'd0, 1'b1, 25'd16777215});
    chk("t4_next25", at25(m0 + 1), 64'd5);
    chk("t4_nofirst25", at25(m0 + 2), 64'd10);
    chk("t4_nosat32", at32(n0), 64'd25165821);

    // T5 backpressure: six results, four slots
    i_ready = 0;
    n0 = got32.size();
    for (int k = 0; k < 6; k++) send(24'(11 + k), 24'd0, 1, 1);
    run(12);
    chk("t5_count_full", {61'd0, o_count}, 64'd4);
    chk("t5_ready_low", {63'd0, o_ready}, 64'd0);
    chk("t5_held", 64'(beat_q.size()), 64'd2);
    i_ready = 1;
    drain(100);
    chk("t5_total", 64'(got32.size() - n0), 64'd6);
    for (int k = 0; k < 6; k++) chk("t5_order", at32(n0 + k), 64'(11 + k));

    // T7 random consumer stalls with mixed groups: same-cycle push and pop
    for (int k = 0; k < 10; k++) begin
      send(24'($urandom_range(0, 400)), 24'hFFFF00, (k % 3) == 0, (k % 2) == 1);
    end
    for (int k = 0; k < 60; k++) begin
      i_ready = 1'($urandom_range(0, 1));
      tick();
    end
    i_ready = 1;
    drain(100);

    // T6 reset with two results buffered and one beat in S1
    i_ready = 0;
    send(24'd21, 24'd0, 1, 1);
    send(24'd22, 24'd0, 1, 1);
    run(4);
    chk("t6_buffered", {61'd0, o_count}, 64'd2);
    send(24'd23, 24'd0, 1, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {63'd0, o_valid}, 64'd0);
    chk("t6_rst_count", {61'd0, o_count}, 64'd0);
    chk("t6_rst_ready", {63'd0, o_ready}, 64'd0);
    model_clear();
    run(2);
    rst_n = 1'b1;
    n0 = got32.size();
    i_ready = 1;
    send(24'd9, 24'd0, 1, 1);
    drain(50);
    chk("t6_count", 64'(got32.size() - n0), 64'd1);
    chk("t6_data", at32(n0), 64'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
